// File: rtl/mem_region_decoder_pkg.sv
// Shared types and default memory map for the memory region decoder.
// Holds the FSM state encoding, the default region table and the
// select-width helper used to size region indices.
package mem_region_pkg;

    // Access sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_NUM_REG = 4;
    localparam int DEF_WAIT_W  = 4;

    // Default map, region 0 in the least significant slice:
    //   r0 0x1000_0000..0x13FF_FFFF  r1 0x1400_0000..0x17FF_FFFF
    //   r2 0x4802_2000..0x4802_2FFF  r3 0x44E1_0000..0x44E1_1FFF
    localparam logic [DEF_NUM_REG*DEF_ADDR_W-1:0] DEF_REG_BASE = {
        32'h44E1_0000, 32'h4802_2000, 32'h1400_0000, 32'h1000_0000
    };
    localparam logic [DEF_NUM_REG*DEF_ADDR_W-1:0] DEF_REG_LIMIT = {
        32'h44E1_1FFF, 32'h4802_2FFF, 32'h17FF_FFFF, 32'h13FF_FFFF
    };
    localparam logic [DEF_NUM_REG*DEF_WAIT_W-1:0] DEF_REG_WAIT = {
        4'd3, 4'd2, 4'd0, 4'd0
    };

    // Width of a region index: never narrower than one bit
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_region_decoder_if.sv
// Request/chip-select bus of the memory region decoder.
// The requester uses the master modport, the decoder the slave modport.
interface mem_region_decoder_if
    import mem_region_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_REG = DEF_NUM_REG,
    parameter int SEL_W   = sel_width(NUM_REG)
);
    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_ready;
    logic [NUM_REG-1:0]  cs_n;
    logic [SEL_W-1:0]    sel_idx;
    logic                done;
    logic                decode_err;
    logic [7:0]          err_cnt;
    logic [ADDR_W-1:0]   last_err_addr;

    modport master (
        output req_valid, req_addr,
        input  req_ready, cs_n, sel_idx, done, decode_err, err_cnt, last_err_addr
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, cs_n, sel_idx, done, decode_err, err_cnt, last_err_addr
    );

endinterface

// File: rtl/mem_region_decoder_region_match.sv
// Combinational priority address matcher.
// Compares an address against every [base, limit] window (inclusive,
// unsigned) and reports whether any matched and the lowest matching index.
module region_match
    import mem_region_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_REG = DEF_NUM_REG,
    parameter logic [NUM_REG*ADDR_W-1:0] REG_BASE  = DEF_REG_BASE,
    parameter logic [NUM_REG*ADDR_W-1:0] REG_LIMIT = DEF_REG_LIMIT,
    parameter int SEL_W   = sel_width(NUM_REG)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [SEL_W-1:0]  idx_o
);

    // Scan from the highest index down so the lowest overlapping region wins
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_REG - 1; i >= 0; i--) begin
            if ((addr_i >= REG_BASE[i*ADDR_W +: ADDR_W]) &&
                (addr_i <= REG_LIMIT[i*ADDR_W +: ADDR_W])) begin
                hit_o = 1'b1;
                idx_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_region_decoder.sv
// Memory region decoder top.
// Accepts one access at a time, decodes it against the region table,
// asserts the matching active-low chip select for the region's wait
// states plus one cycle, then pulses done. Misses pulse decode_err and
// are counted and logged. Every output comes straight from a register.
module mem_region_decoder
    import mem_region_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_REG = DEF_NUM_REG,
    parameter logic [NUM_REG*ADDR_W-1:0] REG_BASE  = DEF_REG_BASE,
    parameter logic [NUM_REG*ADDR_W-1:0] REG_LIMIT = DEF_REG_LIMIT,
    parameter int WAIT_W  = DEF_WAIT_W,
    parameter logic [NUM_REG*WAIT_W-1:0] REG_WAIT  = DEF_REG_WAIT
) (
    input  logic                 clk,
    input  logic                 nRESET,
    mem_region_decoder_if.slave  bus
);

    localparam int SEL_W = sel_width(NUM_REG);

    // Miss counter that sticks at its maximum instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e              state_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                ready_q;
    logic [NUM_REG-1:0]  cs_n_q;
    logic [SEL_W-1:0]    sel_q;
    logic                done_q;
    logic                err_q;
    logic [7:0]          err_cnt_q;
    logic [ADDR_W-1:0]   last_err_q;

    logic                match_hit;
    logic [SEL_W-1:0]    match_idx;
    logic [WAIT_W-1:0]   wait_d;
    logic [NUM_REG-1:0]  cs_n_d;
    logic [7:0]          err_cnt_d;
    logic                accept;

    region_match #(
        .ADDR_W    (ADDR_W),
        .NUM_REG   (NUM_REG),
        .REG_BASE  (REG_BASE),
        .REG_LIMIT (REG_LIMIT),
        .SEL_W     (SEL_W)
    ) u_match (
        .addr_i (bus.req_addr),
        .hit_o  (match_hit),
        .idx_o  (match_idx)
    );

    // req_ready is high exactly in IDLE, so this is the acceptance strobe
    assign accept    = bus.req_valid && ready_q;
    assign err_cnt_d = sat_inc(err_cnt_q);

    // Wait-state count and chip-select pattern of the region being hit
    always_comb begin
        wait_d = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (match_idx == SEL_W'(i)) begin
                wait_d = REG_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
        cs_n_d = ~(NUM_REG'(1) << match_idx);
    end

    // Access FSM with registered outputs; reset aborts any access at once
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            cs_n_q     <= '1;
            sel_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (match_hit) begin
                            state_q <= ST_ACTIVE;
                            sel_q   <= match_idx;
                            cs_n_q  <= cs_n_d;
                            cnt_q   <= wait_d;
                        end else begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_cnt_q  <= err_cnt_d;
                            last_err_q <= bus.req_addr;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Select stays low for the loaded count plus one cycle
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        cs_n_q  <= '1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    cs_n_q  <= '1;
                end
            endcase
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.cs_n          = cs_n_q;
    assign bus.sel_idx       = sel_q;
    assign bus.done          = done_q;
    assign bus.decode_err    = err_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.last_err_addr = last_err_q;

endmodule

// File: doc/mem_region_decoder.md
MEM_REGION_DECODER -- requirements
Module: mem_region_decoder

Interface
REQ-001 Parameter ADDR_W, default 32: request address width.
REQ-002 Parameter NUM_REG, default 4: number of decoded regions (1..16).
REQ-003 Parameter REG_BASE, default {0x44E1_0000, 0x4802_2000, 0x1400_0000, 0x1000_0000}: packed NUM_REG*ADDR_W inclusive lower bounds, region 0 in the LSBs.
REQ-004 Parameter REG_LIMIT, default {0x44E1_1FFF, 0x4802_2FFF, 0x17FF_FFFF, 0x13FF_FFFF}: packed inclusive upper bounds, same order.
REQ-005 Parameter WAIT_W, default 4: wait-state counter width.
REQ-006 Parameter REG_WAIT, default {4'd3, 4'd2, 4'd0, 4'd0}: packed per-region wait states.
REQ-007 Derived constant SEL_W = max(1, clog2(NUM_REG)).
REQ-008 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 nRESET  in  1  asynchronous, active-low reset.
REQ-011 req_valid  in  1  access request.
REQ-012 req_addr  in  ADDR_W  access address, sampled on acceptance.
REQ-013 req_ready  out  1  high only in IDLE.
REQ-014 cs_n  out  NUM_REG  active-low chip selects; at most one bit is low.
REQ-015 sel_idx  out  SEL_W  index of the active region; holds its last value otherwise.
REQ-016 done  out  1  one-cycle pulse at the end of a successful access.
REQ-017 decode_err  out  1  one-cycle pulse when an address misses all regions.
REQ-018 err_cnt  out  8  saturating miss counter.
REQ-019 last_err_addr  out  ADDR_W  address of the most recent miss.

Function
REQ-020 A request is accepted on a rising edge where req_valid=1 and req_ready=1; req_valid is ignored at all other times.
REQ-021 Region i hits when REG_BASE[i] <= req_addr <= REG_LIMIT[i], using unsigned full-width compares.
REQ-022 If regions overlap, the lowest index wins.
REQ-023 FSM states are IDLE, ACTIVE, DONE and ERR; all outputs are registered.
REQ-024 On acceptance with a hit, the FSM goes IDLE->ACTIVE, sets sel_idx=i, drives cs_n[i]=0 and loads the wait counter with REG_WAIT[i].
REQ-025 In ACTIVE, cs_n[i] stays low for exactly REG_WAIT[i]+1 cycles, with the counter decrementing each cycle; when the count is 0 the FSM goes ACTIVE->DONE.
REQ-026 In DONE: cs_n is all ones and done=1 for one cycle; the FSM then goes DONE->IDLE.
REQ-027 On acceptance with a miss, the FSM goes IDLE->ERR.
REQ-028 In ERR: decode_err=1 for one cycle, cs_n is all ones, last_err_addr is captured, err_cnt increments and holds at 255, and the FSM then goes ERR->IDLE.
REQ-029 Minimum request-to-request spacing is REG_WAIT[i]+3 cycles for a hit and 2 cycles for a miss; back-to-back requests need no idle cycle beyond the return to IDLE.
REQ-030 req_addr changes after acceptance have no effect on the access in progress.
REQ-031 done and decode_err are never high in the same cycle.

Reset
REQ-032 When nRESET=0: state=IDLE, req_ready=1, cs_n all ones, sel_idx=0, done=0, decode_err=0, err_cnt=0, last_err_addr=0, wait counter=0.
REQ-033 Reset during ACTIVE aborts the access; cs_n deasserts asynchronously and no done pulse is issued.
REQ-034 Reset release is synchronous to clk; the first acceptance is possible on the first rising edge after deassertion.

Structure
REQ-035 Package mem_region_pkg holds the FSM state enum, the default memory-map base/limit constants and the SEL_W helper function.
REQ-036 One sub-module, region_match, holds the combinational priority compare; it outputs hit and idx and is instantiated once.

Verification
REQ-037 Reset, then request 0x1000_0000 -> cs_n=4'b1110 for 1 cycle, sel_idx=0, done the next cycle, req_ready high again after that.
REQ-038 Request 0x44E1_1FFF (upper boundary) -> cs_n=4'b0111 for 4 cycles, done pulse, sel_idx=3; request 0x44E1_2000 -> decode_err, last_err_addr=0x44E1_2000, err_cnt=1.
REQ-039 Request 0x17FF_FFFF and then 0x1800_0000 back-to-back -> first access is a region-1 hit with done, second is a decode_err; no overlap of cs_n and decode_err.
REQ-040 300 consecutive misses at address 0 -> err_cnt saturates at 255 with no wrap.
REQ-041 Assert nRESET low in the 2nd cycle of a region-3 access -> cs_n=4'b1111 immediately, no done pulse, err_cnt=0.
REQ-042 NUM_REG=2 with overlapping regions [0x0,0xFF] and [0x80,0x1FF], request 0x90 -> region 0 selected.
